sprite_overlay: RTL

SPRITE_OVERLAY -- requirements
Module: sprite_overlay

---
 rtl/sprite_overlay.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sprite_overlay.sv
// Draws a solid sprite over a timing-generator pixel stream with a two-stage pipeline.
// Sprite moves are requested via a valid/ready handshake and applied only at frame boundaries.
module sprite_overlay #(
    parameter int          H_PIXELS  = 640,
    parameter int          V_PIXELS  = 480,
    parameter int          SPR_W     = 16,
    parameter int          SPR_H     = 16,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter logic [11:0] SPR_COLOR = 12'hF00
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       disp_enbl_in,
    input  logic [9:0] h_coord,
    input  logic [9:0] v_coord,
    input  logic       pos_valid,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       pos_ready,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick
);

    localparam logic [9:0]  X_MAX   = 10'(H_PIXELS - SPR_W);
    localparam logic [9:0]  Y_MAX   = 10'(V_PIXELS - SPR_H);
    localparam logic [9:0]  X_CTR   = 10'((H_PIXELS - SPR_W) / 2);
    localparam logic [9:0]  Y_CTR   = 10'((V_PIXELS - SPR_H) / 2);
    localparam logic [9:0]  V_BOUND = 10'(V_PIXELS);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic        frame_tick_q, frame_tick_d;
    logic        hit_q, hit_d;
    logic        de_q, de_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d;
    logic        boundary_s;

    function automatic logic [9:0] clamp(input logic [9:0] val, input logic [9:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

    assign boundary_s = (h_coord == 10'd0) && (v_coord == V_BOUND);
    assign pos_ready  = (state_q == IDLE) && !rst;

    // Position handshake and boundary-synchronous update of the active position.
    always_comb begin
        state_d  = state_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        case (state_q)
            IDLE: begin
                if (pos_valid && pos_ready) begin
                    pend_x_d = clamp(pos_x, X_MAX);
                    pend_y_d = clamp(pos_y, Y_MAX);
                    state_d  = PENDING;
                end else begin
                    state_d  = IDLE;
                end
            end
            PENDING: begin
                if (boundary_s) begin
                    act_x_d = pend_x_q;
                    act_y_d = pend_y_q;
                    state_d = IDLE;
                end else begin
                    state_d = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel pipeline: stage 1 evaluates the hit window, stage 2 picks the colour.
    always_comb begin
        frame_tick_d = boundary_s;
        hit_d = ({1'b0, h_coord} >= {1'b0, act_x_q}) &&
                ({1'b0, h_coord} <  ({1'b0, act_x_q} + SPR_W11)) &&
                ({1'b0, v_coord} >= {1'b0, act_y_q}) &&
                ({1'b0, v_coord} <  ({1'b0, act_y_q} + SPR_H11));
        de_d  = disp_enbl_in;
        hs1_d = h_sync_in;
        vs1_d = v_sync_in;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        if (!de_q) begin
            rgb_d = 12'h000;
        end else if (hit_q) begin
            rgb_d = SPR_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // State and pipeline registers; syncs reset to their inactive-high level.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_x_q     <= 10'd0;
            pend_y_q     <= 10'd0;
            act_x_q      <= X_CTR;
            act_y_q      <= Y_CTR;
            frame_tick_q <= 1'b0;
            hit_q        <= 1'b0;
            de_q         <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            rgb_q        <= 12'h000;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            frame_tick_q <= frame_tick_d;
            hit_q        <= hit_d;
            de_q         <= de_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb_q        <= rgb_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign h_sync_out = hs2_q;
    assign v_sync_out = vs2_q;
    assign frame_tick = frame_tick_q;

endmodule
